// File: rtl/coin_pulse_encoder_pkg.sv
// Shared constants, coin codes and FSM state encoding for the coin pulse encoder.
// Counter widths are derived here so every file sizes its registers identically.
package coin_pulse_encoder_pkg;

  localparam int GAP_CYCLES   = 8;
  localparam int STUCK_CYCLES = 64;
  localparam int PULSE_MIN    = 2;
  localparam int PULSE_SAT    = 4;

  localparam int WIDTH_W = $clog2(STUCK_CYCLES + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W   = $clog2(PULSE_SAT + 1);

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_1    = 2'd1,
    COIN_2    = 2'd2,
    COIN_3    = 2'd3
  } coin_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2,
    JAM  = 2'd3
  } state_e;

endpackage

// File: rtl/coin_pulse_encoder_if.sv
// Validator-side bus of the coin pulse encoder.
// No backpressure: coin and reject are single-cycle strobes the consumer must take when they appear.
interface coin_pulse_encoder_if;
  logic       pulse_in;
  logic       enable;
  logic [1:0] coin;
  logic       reject;
  logic       busy;

  modport master (output pulse_in, enable, input coin, reject, busy);
  modport slave  (input pulse_in, enable, output coin, reject, busy);
endinterface

// File: rtl/coin_pulse_encoder_sync.sv
// Two-flop synchronizer for the raw validator line plus rise/fall detection.
// All flops reset to 1 so a line held high through reset never produces a rising edge.
module coin_pulse_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pulse_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pulse_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;
endmodule

// File: rtl/coin_pulse_encoder.sv
// Counts validator pulses per burst and emits a one-cycle coin code, or a reject strobe for bad bursts.
// Define COIN_GLITCH_FILTER_EN to ignore pulses shorter than PULSE_MIN synced cycles.
module coin_pulse_encoder
  import coin_pulse_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  coin_pulse_encoder_if.slave  bus,
  output state_e               state_dbg
);
  logic               level;
  logic               rise;
  logic               fall;
  logic               pulse_counts;
  state_e             state_q, state_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  coin_e              coin_q, coin_d;
  logic               reject_q, reject_d;

  coin_pulse_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .pulse_in (bus.pulse_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

`ifdef COIN_GLITCH_FILTER_EN
  assign pulse_counts = (width_q >= WIDTH_W'(PULSE_MIN));
`else
  assign pulse_counts = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      width_q  <= '0;
      gap_q    <= '0;
      pcnt_q   <= '0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      pcnt_q   <= pcnt_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    gap_d    = gap_q;
    pcnt_d   = pcnt_q;
    coin_d   = COIN_NONE;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Hold off during the emission cycle so a new burst never overlaps a coin strobe.
        if (rise && coin_q == COIN_NONE) begin
          state_d = HIGH;
          width_d = WIDTH_W'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          if (pulse_counts && pcnt_q != CNT_W'(PULSE_SAT)) pcnt_d = pcnt_q + CNT_W'(1);
          gap_d   = '0;
          state_d = GAP;
        end else if (width_q == WIDTH_W'(STUCK_CYCLES - 1)) begin
          reject_d = 1'b1;
          width_d  = '0;
          gap_d    = '0;
          state_d  = JAM;
        end else begin
          width_d = width_q + WIDTH_W'(1);
        end
      end
      GAP: begin
        // Closing wins over a rise landing in the same cycle.
        if (gap_q == GAP_W'(GAP_CYCLES)) begin
          if (pcnt_q != '0 && pcnt_q < CNT_W'(PULSE_SAT) && bus.enable) coin_d = coin_e'(pcnt_q[1:0]);
          else reject_d = 1'b1;
          pcnt_d  = '0;
          gap_d   = '0;
          width_d = '0;
          state_d = IDLE;
        end else if (rise) begin
          width_d = WIDTH_W'(1);
          state_d = HIGH;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      JAM: begin
        if (level) begin
          gap_d = '0;
        end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          pcnt_d  = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
    endcase
  end

  assign bus.coin   = coin_q;
  assign bus.reject = reject_q;
  assign bus.busy   = (state_q != IDLE);
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_coin_pulse_encoder.sv
// Bench for coin_pulse_encoder: table vectors, hand-built corner sequences and random bursts,
// all compared cycle by cycle against a run-length model of the validator line.
module tb_coin_pulse_encoder;
  import coin_pulse_encoder_pkg::*;

  localparam int MAXC = 2048;
  localparam int LAT  = 12;   // raw fall (first low drive index) to coin cycle
  localparam int NV   = 9;

  typedef struct {
    int n_pulses;
    int high;
    int low;
    bit en;
    int exp_coins;
    int exp_code;
    int exp_rejs;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_e state_dbg;

  coin_pulse_encoder_if bus();

  coin_pulse_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  bit         wave[MAXC];
  bit         en_w[MAXC];
  int         t_len;
  bit         pre_lvl;
  logic [1:0] got_coin[MAXC];
  logic       got_rej[MAXC];
  logic       got_busy[MAXC];
  int         exp_coin_a[MAXC+128];
  bit         exp_rej_a[MAXC+128];
  logic [2:0] exp_q[$];
  int         codes[$];
  vec_t       vec[NV];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input bit pre);
    bus.pulse_in = pre;
    bus.enable   = 1'b0;
    pre_lvl      = pre;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic void add_seg(input bit v, input int len, input bit e);
    for (int i = 0; i < len; i++) begin
      wave[t_len] = v;
      en_w[t_len] = e;
      t_len++;
    end
  endfunction

  function automatic void add_burst(input int n, input int h, input int l, input bit e);
    for (int p = 0; p < n; p++) begin
      add_seg(1'b1, h, e);
      if (p < n - 1) add_seg(1'b0, l, e);
    end
  endfunction

  // Synced line as seen by the FSM in cycle c: two sync flops behind the drive index.
  function automatic bit lvl(input int c);
    if (c < 1) return 1'b1;
    if (c == 1) return pre_lvl;
    if (c - 2 < t_len) return wave[c-2];
    return wave[t_len-1];
  endfunction

  function automatic bit en_at(input int c);
    return (c < t_len) ? en_w[c] : en_w[t_len-1];
  endfunction

  function automatic bit pulse_ok(input int len);
`ifdef COIN_GLITCH_FILTER_EN
    return len >= PULSE_MIN;
`else
    return len >= 1;
`endif
  endfunction

  // Walks the synced line as runs of highs and lows and places the expected strobes.
  function automatic void build_model();
    int c, start, len, f, g, cnt, cc, k, lows, block_at, lim;
    bit done;
    lim = t_len + 40;
    for (int i = 0; i < MAXC + 128; i++) begin
      exp_coin_a[i] = 0;
      exp_rej_a[i]  = 1'b0;
    end
    block_at = -1;
    c = 0;
    while (c < t_len) begin
      if (!lvl(c) || lvl(c-1) || c == block_at) begin
        c++;
        continue;
      end
      cnt = 0;
      start = c;
      done = 1'b0;
      while (!done) begin
        len = 0;
        while (lvl(start + len) && len < STUCK_CYCLES) len++;
        if (len >= STUCK_CYCLES) begin
          exp_rej_a[start + STUCK_CYCLES] = 1'b1;
          k = start + STUCK_CYCLES;
          lows = 0;
          while (lows < GAP_CYCLES && k < lim) begin
            lows = lvl(k) ? 0 : lows + 1;
            k++;
          end
          c = k;
          done = 1'b1;
        end else begin
          f = start + len;
          if (pulse_ok(len) && cnt < PULSE_SAT) cnt++;
          g = 0;
          while (!lvl(f + g) && g <= GAP_CYCLES) g++;
          if (g <= GAP_CYCLES) begin
            start = f + g;
          end else begin
            cc = f + 1 + GAP_CYCLES;
            if (cnt >= 1 && cnt <= 3 && en_at(cc)) begin
              exp_coin_a[cc+1] = cnt;
              block_at = cc + 1;
            end else begin
              exp_rej_a[cc+1] = 1'b1;
            end
            c = cc + 1;
            done = 1'b1;
          end
        end
      end
    end
    exp_q.delete();
    for (int i = 0; i < t_len; i++) exp_q.push_back({exp_rej_a[i], 2'(exp_coin_a[i])});
  endfunction

  task automatic run_wave();
    for (int i = 0; i < t_len; i++) begin
      @(posedge clk);
      #1;
      bus.pulse_in = wave[i];
      bus.enable   = en_w[i];
      @(negedge clk);
      got_coin[i] = bus.coin;
      got_rej[i]  = bus.reject;
      got_busy[i] = bus.busy;
    end
  endtask

  task automatic run_and_check(input string tag);
    logic [2:0] e;
    build_model();
    run_wave();
    for (int c = 0; c < t_len; c++) begin
      e = exp_q.pop_front();
      check($sformatf("%s coin@%0d", tag, c), int'(got_coin[c]), int'(e[1:0]));
      check($sformatf("%s reject@%0d", tag, c), int'(got_rej[c]), int'(e[2]));
      check($sformatf("%s excl@%0d", tag, c), int'(got_coin[c] != 2'd0 && got_rej[c]), 0);
    end
  endtask

  function automatic void tally(output int ncoin, output int first, output int nrej, output int nbusy);
    ncoin = 0; first = -1; nrej = 0; nbusy = 0;
    codes.delete();
    for (int c = 0; c < t_len; c++) begin
      if (got_coin[c] != 2'd0) begin
        if (first < 0) first = c;
        ncoin++;
        codes.push_back(int'(got_coin[c]));
      end
      if (got_rej[c]) nrej++;
      if (got_busy[c]) nbusy++;
    end
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ncoin, first, nrej, nbusy, fall_idx, last_code;
    vec[0] = '{2, 4, 4,  1'b1, 1, 2, 0};
    vec[1] = '{1, 3, 5,  1'b1, 1, 1, 0};
    vec[2] = '{3, 2, 3,  1'b1, 1, 3, 0};
    vec[3] = '{5, 2, 2,  1'b1, 0, 0, 1};
    vec[4] = '{4, 3, 3,  1'b1, 0, 0, 1};
    vec[5] = '{2, 4, 4,  1'b0, 0, 0, 1};
    vec[6] = '{3, 3, 8,  1'b1, 1, 3, 0};
    vec[7] = '{2, 3, 20, 1'b1, 2, 1, 0};
`ifdef COIN_GLITCH_FILTER_EN
    vec[8] = '{1, 1, 4,  1'b1, 0, 0, 1};
`else
    vec[8] = '{1, 1, 4,  1'b1, 1, 1, 0};
`endif

    // Reset values
    do_reset(1'b0);
    #1;
    check("reset coin", int'(bus.coin), 0);
    check("reset reject", int'(bus.reject), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset state", int'(state_dbg), int'(IDLE));

    for (int v = 0; v < NV; v++) begin
      do_reset(1'b0);
      t_len = 0;
      add_seg(1'b0, 4, vec[v].en);
      add_burst(vec[v].n_pulses, vec[v].high, vec[v].low, vec[v].en);
      fall_idx = t_len;
      add_seg(1'b0, 40, vec[v].en);
      run_and_check($sformatf("vec%0d", v));
      tally(ncoin, first, nrej, nbusy);
      check($sformatf("vec%0d coins", v), ncoin, vec[v].exp_coins);
      check($sformatf("vec%0d rejects", v), nrej, vec[v].exp_rejs);
      if (vec[v].exp_coins > 0) begin
        last_code = codes[codes.size()-1];
        check($sformatf("vec%0d code", v), last_code, vec[v].exp_code);
      end
      if (vec[v].exp_coins == 1) check($sformatf("vec%0d latency", v), first, fall_idx + LAT);
    end

    // One pulse then three pulses, well separated
    do_reset(1'b0);
    t_len = 0;
    add_seg(1'b0, 4, 1'b1);
    add_burst(1, 4, 4, 1'b1);
    add_seg(1'b0, 20, 1'b1);
    add_burst(3, 3, 3, 1'b1);
    add_seg(1'b0, 40, 1'b1);
    run_and_check("seq13");
    tally(ncoin, first, nrej, nbusy);
    check("seq13 coins", ncoin, 2);
    check("seq13 rejects", nrej, 0);
    if (ncoin == 2) begin
      check("seq13 first code", codes[0], 1);
      check("seq13 second code", codes[1], 3);
    end

    // Enable raised only in the close cycle
    do_reset(1'b0);
    t_len = 0;
    add_seg(1'b0, 4, 1'b0);
    add_burst(2, 4, 4, 1'b0);
    fall_idx = t_len;
    add_seg(1'b0, 40, 1'b0);
    en_w[fall_idx + LAT - 1] = 1'b1;
    run_and_check("late_en");
    tally(ncoin, first, nrej, nbusy);
    check("late_en coins", ncoin, 1);
    check("late_en rejects", nrej, 0);
    check("late_en at", first, fall_idx + LAT);

    // Jammed line: rise seen in cycle 7, reject at 7+64, eight lows 107..114
    do_reset(1'b0);
    t_len = 0;
    add_seg(1'b0, 5, 1'b1);
    add_seg(1'b1, 100, 1'b1);
    add_seg(1'b0, 40, 1'b1);
    run_and_check("jam");
    tally(ncoin, first, nrej, nbusy);
    check("jam rejects", nrej, 1);
    check("jam coins", ncoin, 0);
    check("jam reject@71", int'(got_rej[71]), 1);
    check("jam busy@7", int'(got_busy[7]), 0);
    check("jam busy@8", int'(got_busy[8]), 1);
    check("jam busy@114", int'(got_busy[114]), 1);
    check("jam busy@115", int'(got_busy[115]), 0);

    // Line held high through reset
    do_reset(1'b1);
    t_len = 0;
    add_seg(1'b1, 10, 1'b1);
    add_seg(1'b0, 30, 1'b1);
    run_and_check("held_high");
    tally(ncoin, first, nrej, nbusy);
    check("held_high strobes", ncoin + nrej, 0);
    check("held_high busy", nbusy, 0);

    // Reset in the middle of a burst
    do_reset(1'b0);
    t_len = 0;
    add_seg(1'b0, 5, 1'b1);
    add_burst(2, 4, 4, 1'b1);
    add_seg(1'b0, 3, 1'b1);
    run_wave();
    check("midrst busy before", int'(got_busy[t_len-1]), 1);
    reset_n = 1'b0;
    #1;
    check("midrst coin", int'(bus.coin), 0);
    check("midrst busy", int'(bus.busy), 0);
    check("midrst state", int'(state_dbg), int'(IDLE));
    pre_lvl = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    t_len = 0;
    add_seg(1'b0, 40, 1'b1);
    run_and_check("midrst after");
    tally(ncoin, first, nrej, nbusy);
    check("midrst later strobes", ncoin + nrej, 0);

    // One-cycle spike between two valid pulses
    do_reset(1'b0);
    t_len = 0;
    add_seg(1'b0, 4, 1'b1);
    add_seg(1'b1, 4, 1'b1);
    add_seg(1'b0, 3, 1'b1);
    add_seg(1'b1, 1, 1'b1);
    add_seg(1'b0, 3, 1'b1);
    add_seg(1'b1, 4, 1'b1);
    add_seg(1'b0, 40, 1'b1);
    run_and_check("glitch");
    tally(ncoin, first, nrej, nbusy);
    check("glitch coins", ncoin, 1);
`ifdef COIN_GLITCH_FILTER_EN
    if (ncoin == 1) check("glitch code", codes[0], 2);
`else
    if (ncoin == 1) check("glitch code", codes[0], 3);
`endif

    // Random bursts with enable toggling independently of the line
    for (int r = 0; r < 6; r++) begin
      do_reset(1'b0);
      t_len = 0;
      add_seg(1'b0, 4, 1'b1);
      for (int b = 0; b < 3; b++) begin
        int n;
        n = $urandom_range(1, 5);
        for (int p = 0; p < n; p++) begin
          add_seg(1'b1, $urandom_range(1, 5), $urandom_range(0, 3) != 0);
          if (p < n - 1) add_seg(1'b0, $urandom_range(1, 8), $urandom_range(0, 3) != 0);
        end
        add_seg(1'b0, $urandom_range(14, 24), $urandom_range(0, 3) != 0);
      end
      add_seg(1'b0, 40, 1'b1);
      run_and_check($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
